// File: rtl/auto_sequencer_if.sv
// Control bus between the run sequencer and the UART/RAM/processor side.
// master = sequencer (drives run controls), slave = surrounding datapath.
interface auto_sequencer_if #(
  parameter int BIDX_W = 1
);
  logic              receive_status;
  logic              processor_status;
  logic              tx_status;
  logic              idle_mode;
  logic              reload_ins;
  logic [1:0]        mode;
  logic              ram_mode;
  logic              p_start;
  logic              tx_start;
  logic [BIDX_W-1:0] block_idx;
  logic              error;

  modport master (
    input  receive_status, processor_status, tx_status, idle_mode, reload_ins,
    output mode, ram_mode, p_start, tx_start, block_idx, error
  );

  modport slave (
    output receive_status, processor_status, tx_status, idle_mode, reload_ins,
    input  mode, ram_mode, p_start, tx_start, block_idx, error
  );
endinterface

// File: rtl/auto_sequencer.sv
// Run sequencer: instruction load, N data-block loads, process, transmit, loop.
// Falling-edge state machine behind synchronisers/edge detectors, with a PROCESS/TRANSMIT watchdog.
module auto_sequencer #(
  parameter int DATA_BLOCKS = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT     = 0
) (
  input  logic              clk,
  input  logic              reset,
  auto_sequencer_if.master  bus
);

  localparam int BIDX_W = (DATA_BLOCKS > 1) ? $clog2(DATA_BLOCKS) : 1;
  localparam logic [BIDX_W-1:0]    LAST_IDX = BIDX_W'(DATA_BLOCKS - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = (TIMEOUT > 0) ? TIMEOUT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_PROC = 2'b10;
  localparam logic [1:0] MODE_TX   = 2'b11;

  localparam int IN_RCV  = 0;
  localparam int IN_PROC = 1;
  localparam int IN_TX   = 2;
  localparam int IN_IDLE = 3;
  localparam int IN_RLD  = 4;

  typedef enum logic [2:0] {
    S_LOAD_INS = 3'd0,
    S_LOAD_DAT = 3'd1,
    S_PROCESS  = 3'd2,
    S_TRANSMIT = 3'd3,
    S_IDLE     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  logic [4:0] raw;
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] edge_q;
  logic [4:0] level;

  logic rcv_rise;
  logic prc_fall;
  logic tx_rise;
  logic idle_fall;
  logic rld_fall;
  logic wd_hit;

  state_t             state;
  logic [1:0]         mode_q;
  logic               ram_q;
  logic               p_q;
  logic               tx_q;
  logic [BIDX_W-1:0]  idx_q;
  logic               err_q;
  logic [TIMEOUT_W-1:0] wd_q;

  assign raw = {bus.reload_ins, bus.idle_mode, bus.tx_status,
                bus.processor_status, bus.receive_status};

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level     = sync_q[SYNC_STAGES-1];
  assign rcv_rise  =  level[IN_RCV]  & ~edge_q[IN_RCV];
  assign prc_fall  = ~level[IN_PROC] &  edge_q[IN_PROC];
  assign tx_rise   =  level[IN_TX]   & ~edge_q[IN_TX];
  assign idle_fall = ~level[IN_IDLE] &  edge_q[IN_IDLE];
  assign rld_fall  = ~level[IN_RLD]  &  edge_q[IN_RLD];

  // Limit compare fires on the TIMEOUT-th edge after entry, since entry clears the count.
  assign wd_hit = (TIMEOUT != 0) && (wd_q == WD_LIMIT);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_LOAD_INS;
      mode_q <= MODE_LOAD;
      ram_q  <= 1'b1;
      p_q    <= 1'b0;
      tx_q   <= 1'b0;
      idx_q  <= '0;
      err_q  <= 1'b0;
      wd_q   <= '0;
    end else begin
      p_q  <= 1'b0;
      tx_q <= 1'b0;
      case (state)
        S_LOAD_INS: begin
          if (rcv_rise) begin
            state  <= S_LOAD_DAT;
            mode_q <= MODE_LOAD;
            ram_q  <= 1'b0;
            idx_q  <= '0;
          end
        end

        S_LOAD_DAT: begin
          if (rld_fall) begin
            state  <= S_LOAD_INS;
            mode_q <= MODE_LOAD;
            ram_q  <= 1'b1;
            idx_q  <= '0;
            err_q  <= 1'b0;
            wd_q   <= '0;
          end else if (idle_fall) begin
            state  <= S_IDLE;
            mode_q <= MODE_IDLE;
          end else if (rcv_rise) begin
            if (idx_q == LAST_IDX) begin
              state  <= S_PROCESS;
              mode_q <= MODE_PROC;
              p_q    <= 1'b1;
              wd_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        S_PROCESS: begin
          if (rld_fall) begin
            state  <= S_LOAD_INS;
            mode_q <= MODE_LOAD;
            ram_q  <= 1'b1;
            idx_q  <= '0;
            err_q  <= 1'b0;
            wd_q   <= '0;
          end else if (prc_fall) begin
            state  <= S_TRANSMIT;
            mode_q <= MODE_TX;
            tx_q   <= 1'b1;
            wd_q   <= '0;
          end else if (wd_hit) begin
            state  <= S_ERROR;
            mode_q <= MODE_IDLE;
            err_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        S_TRANSMIT: begin
          if (rld_fall) begin
            state  <= S_LOAD_INS;
            mode_q <= MODE_LOAD;
            ram_q  <= 1'b1;
            idx_q  <= '0;
            err_q  <= 1'b0;
            wd_q   <= '0;
          end else if (tx_rise) begin
            state  <= S_LOAD_DAT;
            mode_q <= MODE_LOAD;
            ram_q  <= 1'b0;
            idx_q  <= '0;
          end else if (wd_hit) begin
            state  <= S_ERROR;
            mode_q <= MODE_IDLE;
            err_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        // ram_mode stays at its entry value unless a reload toggles it.
        S_IDLE: begin
          if (rld_fall) begin
            ram_q <= ~ram_q;
          end else if (idle_fall) begin
            state  <= S_LOAD_DAT;
            mode_q <= MODE_LOAD;
            ram_q  <= 1'b0;
            idx_q  <= '0;
          end
        end

        S_ERROR: begin
          if (rld_fall) begin
            state  <= S_LOAD_INS;
            mode_q <= MODE_LOAD;
            ram_q  <= 1'b1;
            idx_q  <= '0;
            err_q  <= 1'b0;
            wd_q   <= '0;
          end
        end

        default: begin
          state  <= S_LOAD_INS;
          mode_q <= MODE_LOAD;
          ram_q  <= 1'b1;
          idx_q  <= '0;
          err_q  <= 1'b0;
          wd_q   <= '0;
        end
      endcase
    end
  end

  assign bus.mode      = mode_q;
  assign bus.ram_mode  = ram_q;
  assign bus.p_start   = p_q;
  assign bus.tx_start  = tx_q;
  assign bus.block_idx = idx_q;
  assign bus.error     = err_q;

  a_pulse_exclusive: assert property (@(negedge clk) disable iff (!reset) !(p_q && tx_q));
  a_error_state:     assert property (@(negedge clk) disable iff (!reset) err_q == (state == S_ERROR));

endmodule

// File: tb/tb_auto_sequencer.sv
// Randomised and directed checks of auto_sequencer against a phase-level reference model.
module tb_auto_sequencer;

  localparam int DB = 3;
  localparam int SS = 2;
  localparam int TW = 16;
  localparam int TO = 20;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  auto_sequencer_if #(.BIDX_W(BW)) bus ();

  auto_sequencer #(
    .DATA_BLOCKS(DB),
    .SYNC_STAGES(SS),
    .TIMEOUT_W(TW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // drv bits: 0 receive, 1 processor, 2 tx, 3 idle, 4 reload
  logic [4:0] drv;
  logic [4:0] hist [$];

  typedef enum int {M_INS, M_DAT, M_PROC, M_TX, M_IDLE, M_ERR} phase_t;
  phase_t m_ph;
  int     m_blk;
  int     m_age;
  logic   m_ram;
  logic   m_p;
  logic   m_tx;

  function automatic logic [1:0] m_mode();
    case (m_ph)
      M_INS, M_DAT: return 2'b01;
      M_PROC:       return 2'b10;
      M_TX:         return 2'b11;
      default:      return 2'b00;
    endcase
  endfunction

  function automatic void model_reset();
    m_ph  = M_INS;
    m_blk = 0;
    m_age = 0;
    m_ram = 1'b1;
    m_p   = 1'b0;
    m_tx  = 1'b0;
    hist  = {5'd0, 5'd0, 5'd0, 5'd0};
  endfunction

  function automatic void to_load_ins();
    m_ph  = M_INS;
    m_blk = 0;
    m_ram = 1'b1;
  endfunction

  // An input level driven on a rising edge becomes an event on the third falling edge.
  function automatic void model_edge();
    logic [4:0] cur, prev, rise, fall;
    cur  = hist[1];
    prev = hist[0];
    rise = cur & ~prev;
    fall = ~cur & prev;
    m_p  = 1'b0;
    m_tx = 1'b0;
    case (m_ph)
      M_INS: if (rise[0]) begin m_ph = M_DAT; m_blk = 0; m_ram = 1'b0; end
      M_DAT: begin
        if (fall[4]) to_load_ins();
        else if (fall[3]) m_ph = M_IDLE;
        else if (rise[0]) begin
          if (m_blk + 1 == DB) begin m_ph = M_PROC; m_p = 1'b1; m_age = 0; end
          else m_blk++;
        end
      end
      M_PROC: begin
        if (fall[4]) to_load_ins();
        else if (fall[1]) begin m_ph = M_TX; m_tx = 1'b1; m_age = 0; end
        else if (TO != 0 && m_age + 1 == TO) m_ph = M_ERR;
        else m_age++;
      end
      M_TX: begin
        if (fall[4]) to_load_ins();
        else if (rise[2]) begin m_ph = M_DAT; m_blk = 0; m_ram = 1'b0; end
        else if (TO != 0 && m_age + 1 == TO) m_ph = M_ERR;
        else m_age++;
      end
      M_IDLE: begin
        if (fall[4]) m_ram = ~m_ram;
        else if (fall[3]) begin m_ph = M_DAT; m_blk = 0; m_ram = 1'b0; end
      end
      default: if (fall[4]) to_load_ins();
    endcase
  endfunction

  task automatic apply_drv();
    bus.receive_status   = drv[0];
    bus.processor_status = drv[1];
    bus.tx_status        = drv[2];
    bus.idle_mode        = drv[3];
    bus.reload_ins       = drv[4];
  endtask

  // Starts and ends on a rising edge; the DUT acts on the falling edge in between.
  task automatic step();
    hist.push_back(drv);
    void'(hist.pop_front());
    apply_drv();
    @(negedge clk);
    model_edge();
    @(posedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drv = '0;
    apply_drv();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    reset = 1'b1;
  endtask

  // Ends on the rising edge right after PROCESS entry, processor_status held high.
  task automatic goto_process();
    do_reset();
    drv[1] = 1'b1;
    for (int r = 0; r < DB; r++) begin
      drv[0] = 1'b1; steps(3);
      drv[0] = 1'b0; steps(2);
    end
    drv[0] = 1'b1; steps(3);
    drv[0] = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (bus.mode !== 2'b01)   begin bad++; $display("FAIL reset_mode got=%0d want=1", bus.mode); end
    total++; if (bus.ram_mode !== 1'b1) begin bad++; $display("FAIL reset_ram got=%0d want=1", bus.ram_mode); end
    total++; if (bus.p_start !== 1'b0)  begin bad++; $display("FAIL reset_p_start got=%0d want=0", bus.p_start); end
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%0d want=0", bus.tx_start); end
    total++; if (bus.block_idx !== 2'd0) begin bad++; $display("FAIL reset_block_idx got=%0d want=0", bus.block_idx); end
    total++; if (bus.error !== 1'b0)    begin bad++; $display("FAIL reset_error got=%0d want=0", bus.error); end
    @(posedge clk);
    reset = 1'b1;
    steps(4);
    total++; if (bus.mode !== 2'b01 || bus.ram_mode !== 1'b1) begin bad++; $display("FAIL reset_hold got mode=%0d ram=%0d want mode=1 ram=1", bus.mode, bus.ram_mode); end
  endtask

  task automatic test_full_loop();
    do_reset();
    drv[1] = 1'b1;
    drv[0] = 1'b1; steps(3);
    total++; if (bus.mode !== 2'b01 || bus.ram_mode !== 1'b0 || bus.block_idx !== 2'd0) begin bad++; $display("FAIL loop_load_dat got mode=%0d ram=%0d idx=%0d want 1/0/0", bus.mode, bus.ram_mode, bus.block_idx); end
    drv[0] = 1'b0; steps(2);
    for (int r = 1; r < DB; r++) begin
      drv[0] = 1'b1; steps(3);
      total++; if (bus.block_idx !== BW'(r) || bus.p_start !== 1'b0) begin bad++; $display("FAIL loop_block_idx got idx=%0d p_start=%0d want idx=%0d p_start=0", bus.block_idx, bus.p_start, r); end
      drv[0] = 1'b0; steps(2);
    end
    drv[0] = 1'b1; steps(3);
    total++; if (bus.p_start !== 1'b1 || bus.mode !== 2'b10) begin bad++; $display("FAIL loop_p_start got p=%0d mode=%0d want p=1 mode=2", bus.p_start, bus.mode); end
    drv[0] = 1'b0; steps(1);
    total++; if (bus.p_start !== 1'b0 || bus.mode !== 2'b10) begin bad++; $display("FAIL loop_p_start_width got p=%0d mode=%0d want p=0 mode=2", bus.p_start, bus.mode); end
    drv[1] = 1'b0; steps(3);
    total++; if (bus.tx_start !== 1'b1 || bus.mode !== 2'b11 || bus.p_start !== 1'b0) begin bad++; $display("FAIL loop_tx_start got tx=%0d mode=%0d p=%0d want tx=1 mode=3 p=0", bus.tx_start, bus.mode, bus.p_start); end
    steps(1);
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL loop_tx_start_width got tx=%0d want 0", bus.tx_start); end
    drv[2] = 1'b1; steps(3);
    total++; if (bus.mode !== 2'b01 || bus.block_idx !== 2'd0 || bus.ram_mode !== 1'b0) begin bad++; $display("FAIL loop_back got mode=%0d idx=%0d ram=%0d want 1/0/0", bus.mode, bus.block_idx, bus.ram_mode); end
    drv[2] = 1'b0; steps(2);
  endtask

  task automatic test_latency();
    do_reset();
    drv[0] = 1'b1; steps(2);
    total++; if (bus.ram_mode !== 1'b1) begin bad++; $display("FAIL latency_early got ram=%0d want 1", bus.ram_mode); end
    steps(1);
    total++; if (bus.ram_mode !== 1'b0) begin bad++; $display("FAIL latency_on_time got ram=%0d want 0", bus.ram_mode); end
    drv[0] = 1'b0; steps(2);
    for (int r = 1; r < DB; r++) begin
      drv[0] = 1'b1; steps(3);
      drv[0] = 1'b0; steps(2);
    end
    drv[0] = 1'b1; steps(2);
    total++; if (bus.mode !== 2'b01) begin bad++; $display("FAIL latency_mode_early got mode=%0d want 1", bus.mode); end
    steps(1);
    total++; if (bus.mode !== 2'b10) begin bad++; $display("FAIL latency_mode_on_time got mode=%0d want 2", bus.mode); end
    drv[0] = 1'b0;
  endtask

  task automatic test_watchdog();
    goto_process();
    steps(TO - 1);
    total++; if (bus.mode !== 2'b10 || bus.error !== 1'b0) begin bad++; $display("FAIL wd_before got mode=%0d err=%0d want mode=2 err=0", bus.mode, bus.error); end
    steps(1);
    total++; if (bus.mode !== 2'b00 || bus.error !== 1'b1) begin bad++; $display("FAIL wd_expire got mode=%0d err=%0d want mode=0 err=1", bus.mode, bus.error); end
    drv[4] = 1'b1; steps(2);
    drv[4] = 1'b0; steps(3);
    total++; if (bus.mode !== 2'b01 || bus.ram_mode !== 1'b1 || bus.error !== 1'b0 || bus.block_idx !== 2'd0) begin bad++; $display("FAIL wd_recover got mode=%0d ram=%0d err=%0d idx=%0d want 1/1/0/0", bus.mode, bus.ram_mode, bus.error, bus.block_idx); end
  endtask

  task automatic test_async_reset();
    goto_process();
    total++; if (bus.p_start !== 1'b1) begin bad++; $display("FAIL areset_pulse_before got p=%0d want 1", bus.p_start); end
    #2 reset = 1'b0;
    #1;
    total++; if (bus.mode !== 2'b01 || bus.ram_mode !== 1'b1 || bus.p_start !== 1'b0 || bus.tx_start !== 1'b0 || bus.error !== 1'b0 || bus.block_idx !== 2'd0) begin
      bad++; $display("FAIL areset_immediate got mode=%0d ram=%0d p=%0d tx=%0d err=%0d idx=%0d want 1/1/0/0/0/0", bus.mode, bus.ram_mode, bus.p_start, bus.tx_start, bus.error, bus.block_idx);
    end
    drv = '0;
    apply_drv();
    model_reset();
    @(posedge clk);
    reset = 1'b1;
  endtask

  task automatic test_idle();
    do_reset();
    drv[0] = 1'b1; steps(3);
    drv[0] = 1'b0; steps(1);
    drv[3] = 1'b1; steps(2);
    drv[3] = 1'b0; steps(3);
    total++; if (bus.mode !== 2'b00 || bus.ram_mode !== 1'b0) begin bad++; $display("FAIL idle_enter got mode=%0d ram=%0d want 0/0", bus.mode, bus.ram_mode); end
    drv[4] = 1'b1; steps(2);
    drv[4] = 1'b0; steps(3);
    total++; if (bus.mode !== 2'b00 || bus.ram_mode !== 1'b1) begin bad++; $display("FAIL idle_toggle got mode=%0d ram=%0d want 0/1", bus.mode, bus.ram_mode); end
    drv[3] = 1'b1; steps(2);
    drv[3] = 1'b0; steps(3);
    total++; if (bus.mode !== 2'b01 || bus.block_idx !== 2'd0) begin bad++; $display("FAIL idle_exit got mode=%0d idx=%0d want 1/0", bus.mode, bus.block_idx); end
  endtask

  task automatic test_collision();
    int p_seen;
    do_reset();
    for (int r = 0; r < DB; r++) begin
      drv[0] = 1'b1; steps(3);
      drv[0] = 1'b0; steps(2);
    end
    drv[4] = 1'b1; steps(2);
    drv[4] = 1'b0;
    drv[0] = 1'b1;
    p_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.p_start === 1'b1) p_seen++;
    end
    total++; if (bus.mode !== 2'b01 || bus.ram_mode !== 1'b1 || p_seen != 0) begin bad++; $display("FAIL coll_reload_rx got mode=%0d ram=%0d p_pulses=%0d want 1/1/0", bus.mode, bus.ram_mode, p_seen); end
    goto_process();
    steps(TO - 3);
    drv[1] = 1'b0; steps(3);
    total++; if (bus.mode !== 2'b11 || bus.tx_start !== 1'b1 || bus.error !== 1'b0) begin bad++; $display("FAIL coll_done_vs_wd got mode=%0d tx=%0d err=%0d want 3/1/0", bus.mode, bus.tx_start, bus.error); end
    steps(1);
    total++; if (bus.error !== 1'b0 || bus.mode !== 2'b11) begin bad++; $display("FAIL coll_after got mode=%0d err=%0d want 3/0", bus.mode, bus.error); end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    int probs [5] = '{12, 10, 12, 2, 2};
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 99) < probs[b]) drv[b] = ~drv[b];
      step();
      exp = {m_mode(), m_ram, m_p, m_tx, m_blk[1:0], (m_ph == M_ERR)};
      got = {bus.mode, bus.ram_mode, bus.p_start, bus.tx_start, bus.block_idx, bus.error};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random_cycle%0d got=%b want=%b (mode,ram,p,tx,idx,err)", c, got, exp);
      end
    end
  endtask

  initial begin
    drv = '0;
    apply_drv();
    model_reset();
    test_reset();
    test_full_loop();
    test_latency();
    test_watchdog();
    test_async_reset();
    test_idle();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached t=%0t limit=500000", $time);
    $fatal(1, "simulation did not finish");
  end

endmodule
